// File: rtl/dm_pkg.sv
// Shared DMI types: DTM op codes, sticky error codes, response codes and issue FSM states.
package dm;
  typedef enum logic [1:0] {
    DtmNop      = 2'd0,
    DtmRead     = 2'd1,
    DtmWrite    = 2'd2,
    DtmReserved = 2'd3
  } dtm_op_e;

  typedef enum logic [1:0] {
    DmiNoError  = 2'd0,
    DmiReserved = 2'd1,
    DmiOpFailed = 2'd2,
    DmiBusy     = 2'd3
  } dmi_error_e;

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    Issue    = 2'd1,
    WaitResp = 2'd2
  } issue_state_e;

  localparam logic [1:0] RespOk     = 2'd0;
  localparam logic [1:0] RespFailed = 2'd2;
  localparam logic [1:0] RespBusy   = 2'd3;
endpackage

// File: rtl/dmi_access_fifo.sv
// Synchronous request FIFO with wrap-bit pointers and a flush that can spare the head entry.
module dmi_access_fifo #(
  parameter int Width = 41,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             keep_head,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] One = (PtrW+1)'(1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW:0]    wptr_q, rptr_q, rptr_nx;

  assign empty   = wptr_q == rptr_q;
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign rdata   = mem[rptr_q[PtrW-1:0]];
  assign rptr_nx = (pop && !empty) ? rptr_q + One : rptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      rptr_q <= rptr_nx;
      // A head that is still being presented survives the flush; popping it empties the queue.
      if (flush) wptr_q <= (keep_head && !empty && !pop) ? rptr_q + One : rptr_nx;
      else if (push && !full) begin
        mem[wptr_q[PtrW-1:0]] <= wdata;
        wptr_q                <= wptr_q + One;
      end
    end
  end
endmodule

// File: rtl/dmi_access_engine.sv
// DMI access engine: turns TAP DR scans into queued DMI requests and keeps sticky DTM status.
module dmi_access_engine
  import dm::*;
#(
  parameter int AddrWidth = 7,
  parameter int DataWidth = 32,
  parameter int FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 capture_dr_i,
  input  logic                 shift_dr_i,
  input  logic                 update_dr_i,
  input  logic                 dmi_access_i,
  input  logic                 dmi_reset_i,
  input  logic                 dmi_hardreset_i,
  input  logic                 dmi_tdi_i,
  output logic                 dmi_tdo_o,
  output logic [1:0]           dmi_error_o,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic [DataWidth-1:0] req_data_o,
  output logic [1:0]           req_op_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  input  logic [DataWidth-1:0] resp_data_i,
  input  logic [1:0]           resp_resp_i,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o
);
  localparam int DrWidth = AddrWidth + DataWidth + 2;

  logic [DrWidth-1:0]   dr_q, head;
  logic [AddrWidth-1:0] last_addr_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 read_pending_q, discard_q;
  dmi_error_e           error_q;
  issue_state_e         state_q, state_d;
  logic                 capture, shift, update, full, empty, busy, push;
  logic                 issuing, accept, head_is_read;
  logic [1:0]           status;

  assign capture      = capture_dr_i & dmi_access_i;
  assign shift        = shift_dr_i & dmi_access_i;
  assign update       = update_dr_i & dmi_access_i;
  assign busy         = full | read_pending_q;
  assign push         = update & !dmi_hardreset_i & (error_q == DmiNoError) & !busy &
                        ((dr_q[1:0] == DtmRead) | (dr_q[1:0] == DtmWrite));
  assign issuing      = state_q == Issue;
  assign accept       = issuing & req_ready_i;
  assign head_is_read = head[1:0] == DtmRead;
  assign status       = (error_q != DmiNoError) ? error_q : (read_pending_q ? DmiBusy : DmiNoError);
  assign dmi_tdo_o    = dr_q[0];
  assign dmi_error_o  = error_q;

  dmi_access_fifo #(.Width(DrWidth), .Depth(FifoDepth)) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (push),
    .pop      (accept),
    .flush    (dmi_hardreset_i),
    .keep_head(issuing),
    .wdata    (dr_q),
    .rdata    (head),
    .full     (full),
    .empty    (empty)
  );

  // A push this cycle lets Idle skip straight to Issue so the request shows one cycle after update.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:     if ((!empty && !dmi_hardreset_i) || push) state_d = Issue;
      Issue:    if (req_ready_i) state_d = head_is_read ? WaitResp : Idle;
      WaitResp: if (resp_valid_i) state_d = Idle;
      default:  state_d = Idle;
    endcase
  end

  always_comb begin
    req_valid_o  = issuing;
    req_addr_o   = '0;
    req_data_o   = '0;
    req_op_o     = '0;
    resp_ready_o = 1'b1;
    if (issuing) {req_addr_o, req_data_o, req_op_o} = head;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= Idle;
      dr_q           <= '0;
      last_addr_q    <= '0;
      rdata_q        <= '0;
      read_pending_q <= 1'b0;
      discard_q      <= 1'b0;
      error_q        <= DmiNoError;
    end else begin
      state_q <= state_d;
      if (shift)        dr_q <= {dmi_tdi_i, dr_q[DrWidth-1:1]};
      else if (capture) dr_q <= {last_addr_q, rdata_q, status};
      if (capture && read_pending_q)                   error_q <= DmiBusy;
      if (update && error_q == DmiNoError && busy)     error_q <= DmiBusy;
      if (state_q == WaitResp && resp_valid_i) begin
        discard_q <= 1'b0;
        if (!discard_q && !dmi_hardreset_i) begin
          rdata_q        <= resp_data_i;
          read_pending_q <= 1'b0;
          if (resp_resp_i == RespFailed)    error_q <= DmiOpFailed;
          else if (resp_resp_i == RespBusy) error_q <= DmiBusy;
        end
      end
      if (push) begin
        last_addr_q <= dr_q[DrWidth-1 -: AddrWidth];
        if (dr_q[1:0] == DtmRead) read_pending_q <= 1'b1;
      end
      // Any read already handed to (or being offered to) the DM is drained but its data dropped.
      if (dmi_hardreset_i) begin
        dr_q           <= '0;
        read_pending_q <= 1'b0;
        error_q        <= DmiNoError;
        if ((state_q == WaitResp && !resp_valid_i) || (issuing && head_is_read)) discard_q <= 1'b1;
      end
      if (dmi_reset_i) error_q <= DmiNoError;
    end
  end
endmodule
